tlul_cmd_sequencer: RTL and testbench

- Host-side initiator for the TL-UL master's control port. It drives start_trans, trans_type, address, size, write_data and write_mask, and consumes trans_done and read_data.
- Queues software/testbench commands in a small FIFO and issues them one at a time.
- Returns one tagged response per command through a valid/ready port.
- Adds timeout and illegal-type error reporting so a hung slave never deadlocks the host.

---
 rtl/tlul_cmd_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_tlul_cmd_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_cmd_sequencer.sv
// Host-side command sequencer for a TL-UL master control port: buffers commands,
// issues them one at a time and returns one tagged response per command.
module tlul_cmd_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH     = 3,
    parameter int TAG_WIDTH      = 4,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk_24,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_type,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [SIZE_WIDTH-1:0]        cmd_size,
    input  logic [DATA_WIDTH-1:0]        cmd_wdata,
    input  logic [MASK_WIDTH-1:0]        cmd_wmask,
    input  logic [TAG_WIDTH-1:0]         cmd_tag,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [TAG_WIDTH-1:0]         rsp_tag,
    output logic [1:0]                   rsp_type,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         start_trans,
    output logic [1:0]                   trans_type,
    output logic [ADDR_WIDTH-1:0]        address,
    output logic [SIZE_WIDTH-1:0]        size,
    output logic [DATA_WIDTH-1:0]        write_data,
    output logic [MASK_WIDTH-1:0]        write_mask,
    input  logic                         trans_done,
    input  logic [DATA_WIDTH-1:0]        read_data,
    output logic                         busy,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0]      TYPE_GET      = 2'd0;
    localparam logic [1:0]      TYPE_RESERVED = 2'd3;
    localparam logic [TO_W-1:0] TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_next;

    logic [1:0]            fifo_type  [CMD_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
    logic [SIZE_WIDTH-1:0] fifo_size  [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
    logic [MASK_WIDTH-1:0] fifo_wmask [CMD_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag   [CMD_DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TO_W-1:0]  timer;

    logic push, pop, fifo_empty;
    logic done_ok, done_timeout;
    logic [1:0] head_type;

    // cmd_ready looks only at the registered count, so a full FIFO never
    // accepts a push even in a cycle where the FSM pops.
    assign cmd_ready  = (count != CNT_W'(CMD_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = cmd_valid && cmd_ready;
    assign head_type  = fifo_type[rd_ptr];
    assign busy       = (state != IDLE) || !fifo_empty;
    assign cmd_count  = count;

    always_ff @(posedge clk_24) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        start_trans  = 1'b0;
        rsp_valid    = 1'b0;
        done_ok      = 1'b0;
        done_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = (head_type == TYPE_RESERVED) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                start_trans = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                // A completion arriving on the expiry cycle still wins.
                if (trans_done) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (timer == TO_LAST) begin
                    done_timeout = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_24) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_24) begin
        if (push) begin
            fifo_type[wr_ptr]  <= cmd_type;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_size[wr_ptr]  <= cmd_size;
            fifo_wdata[wr_ptr] <= cmd_wdata;
            fifo_wmask[wr_ptr] <= cmd_wmask;
            fifo_tag[wr_ptr]   <= cmd_tag;
        end
    end

    // Master-side fields change only on a pop, which keeps them stable through WAIT.
    always_ff @(posedge clk_24) begin
        if (rst) begin
            trans_type <= '0;
            address    <= '0;
            size       <= '0;
            write_data <= '0;
            write_mask <= '0;
            rsp_tag    <= '0;
            rsp_type   <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            timer      <= '0;
        end else begin
            if (pop) begin
                rsp_tag   <= fifo_tag[rd_ptr];
                rsp_type  <= head_type;
                rsp_rdata <= '0;
                if (head_type == TYPE_RESERVED) begin
                    rsp_err <= 1'b1;
                end else begin
                    rsp_err    <= 1'b0;
                    trans_type <= head_type;
                    address    <= fifo_addr[rd_ptr];
                    size       <= fifo_size[rd_ptr];
                    write_data <= fifo_wdata[rd_ptr];
                    write_mask <= fifo_wmask[rd_ptr];
                end
            end
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + TO_W'(1);
            end
            if (done_ok) begin
                rsp_rdata <= (rsp_type == TYPE_GET) ? read_data : '0;
                rsp_err   <= 1'b0;
            end else if (done_timeout) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tlul_cmd_sequencer.sv
// Scoreboard bench for tlul_cmd_sequencer with a behavioural TL-UL master model
// that completes transactions against a small word memory.
module tb_tlul_cmd_sequencer;

    localparam int AW = 32, DW = 32, MW = 4, SW = 3, TW = 4, DEPTH = 4, TO = 16;

    logic                       clk_24, rst;
    logic                       cmd_valid, cmd_ready;
    logic [1:0]                 cmd_type;
    logic [AW-1:0]              cmd_addr;
    logic [SW-1:0]              cmd_size;
    logic [DW-1:0]              cmd_wdata;
    logic [MW-1:0]              cmd_wmask;
    logic [TW-1:0]              cmd_tag;
    logic                       rsp_valid, rsp_ready;
    logic [TW-1:0]              rsp_tag;
    logic [1:0]                 rsp_type;
    logic [DW-1:0]              rsp_rdata;
    logic                       rsp_err;
    logic                       start_trans;
    logic [1:0]                 trans_type;
    logic [AW-1:0]              address;
    logic [SW-1:0]              size;
    logic [DW-1:0]              write_data;
    logic [MW-1:0]              write_mask;
    logic                       trans_done, slave_done, manual_done;
    logic [DW-1:0]              read_data;
    logic                       busy;
    logic [$clog2(DEPTH):0]     cmd_count;

    typedef struct {
        logic [TW-1:0] tag;
        logic [1:0]    typ;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } rsp_t;

    typedef struct {
        logic [1:0]    typ;
        logic [AW-1:0] addr;
        int            cyc;
    } st_t;

    rsp_t rsp_obs[$], rsp_exp[$];
    st_t  st_obs[$],  st_exp[$];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int slave_delay = 0;

    logic [DW-1:0] mem [64];
    logic [1:0]    s_typ;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [MW-1:0] s_mask;

    assign trans_done = slave_done | manual_done;

    tlul_cmd_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .SIZE_WIDTH(SW),
        .TAG_WIDTH(TW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_24(clk_24), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .cmd_wmask(cmd_wmask), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_type(rsp_type), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .start_trans(start_trans), .trans_type(trans_type), .address(address),
        .size(size), .write_data(write_data), .write_mask(write_mask),
        .trans_done(trans_done), .read_data(read_data),
        .busy(busy), .cmd_count(cmd_count)
    );

    initial begin
        clk_24 = 1'b0;
        forever #5 clk_24 = ~clk_24;
    end

    always @(posedge clk_24) cyc <= cyc + 1;

    // Monitor: a response is recorded on the cycle its handshake completes.
    initial begin
        forever begin
            @(negedge clk_24);
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1)
                rsp_obs.push_back('{tag: rsp_tag, typ: rsp_type, rdata: rsp_rdata, err: rsp_err, cyc: cyc});
            if (start_trans === 1'b1)
                st_obs.push_back('{typ: trans_type, addr: address, cyc: cyc});
        end
    end

    // Master model: completes slave_delay cycles after start_trans (0 = never).
    initial begin
        slave_done = 1'b0;
        read_data  = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4] = 32'hDEAD_BEEF;
        for (int k = 0; k < 6; k++) mem[16 + k] = 32'hA000_0000 + k;
        forever begin
            @(negedge clk_24);
            if (start_trans === 1'b1 && slave_delay > 0) begin
                s_typ = trans_type; s_addr = address; s_wdata = write_data; s_mask = write_mask;
                repeat (slave_delay) @(posedge clk_24);
                #1;
                if (s_typ == 2'd0) begin
                    read_data = mem[s_addr[7:2]];
                end else begin
                    for (int b = 0; b < MW; b++)
                        if (s_mask[b]) mem[s_addr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    read_data = 32'hBAD0_BAD0;
                end
                slave_done = 1'b1;
                @(posedge clk_24);
                #1;
                slave_done = 1'b0;
                read_data  = 32'h5555_5555;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input logic [1:0] t, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [MW-1:0] m, input logic [TW-1:0] tag,
                            output int acc_cyc, output bit ok);
        @(posedge clk_24);
        #1;
        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_size = 3'd2;
        cmd_wdata = d; cmd_wmask = m; cmd_tag = tag;
        ok = 1'b0;
        acc_cyc = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk_24);
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk_24);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_24);
            if (rsp_obs.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk_24);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk_24);
        #1;
        rst = 1'b0;
        @(negedge clk_24);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (cmd_count !== 3'd0) begin n_fails++; $display("FAIL reset_cmd_count: got %0d want 0", cmd_count); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (start_trans !== 1'b0) begin n_fails++; $display("FAIL reset_start: got %b want 0", start_trans); end
        n_checks++; if (address !== 32'h0 || trans_type !== 2'd0 || write_data !== 32'h0 || write_mask !== 4'h0)
            begin n_fails++; $display("FAIL reset_master_fields: addr %h type %0d wdata %h mask %h want 0", address, trans_type, write_data, write_mask); end
        n_checks++; if (rsp_tag !== 4'd0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || rsp_type !== 2'd0)
            begin n_fails++; $display("FAIL reset_rsp_fields: tag %0d err %b rdata %h type %0d want 0", rsp_tag, rsp_err, rsp_rdata, rsp_type); end
    endtask

    task automatic test_single_get;
        int acc; bit ok; rsp_t r, e; st_t s;
        slave_delay = 5; rsp_ready = 1'b1;
        rsp_exp.push_back('{tag: 4'd3, typ: 2'd0, rdata: 32'hDEAD_BEEF, err: 1'b0, cyc: 0});
        push_cmd(2'd0, 32'h0000_0010, 32'h0, 4'hF, 4'd3, acc, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL get_accept: got none want accepted"); end
        wait_rsp(1, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL get_rsp_timeout: got %0d rsps want 1", rsp_obs.size()); end
        n_checks++; if (st_obs.size() != 1) begin n_fails++; $display("FAIL get_start_count: got %0d want 1", st_obs.size()); end
        if (st_obs.size() > 0) begin
            s = st_obs.pop_front();
            n_checks++; if (s.typ !== 2'd0 || s.addr !== 32'h10) begin n_fails++; $display("FAIL get_start_fields: type %0d addr %h want 0 / 10", s.typ, s.addr); end
            n_checks++; if (s.cyc != acc + 2) begin n_fails++; $display("FAIL get_start_latency: got cycle %0d want %0d", s.cyc, acc + 2); end
            e = rsp_exp.pop_front();
            if (rsp_obs.size() > 0) begin
                r = rsp_obs.pop_front();
                n_checks++; if (r.tag !== e.tag || r.typ !== e.typ) begin n_fails++; $display("FAIL get_rsp_tag: tag %0d type %0d want %0d / %0d", r.tag, r.typ, e.tag, e.typ); end
                n_checks++; if (r.rdata !== e.rdata) begin n_fails++; $display("FAIL get_rsp_rdata: got %h want %h", r.rdata, e.rdata); end
                n_checks++; if (r.err !== e.err) begin n_fails++; $display("FAIL get_rsp_err: got %b want %b", r.err, e.err); end
                n_checks++; if (r.cyc != s.cyc + 6) begin n_fails++; $display("FAIL get_rsp_latency: got cycle %0d want %0d", r.cyc, s.cyc + 6); end
            end
        end
        rsp_exp.delete(); rsp_obs.delete(); st_obs.delete();
    endtask

    task automatic test_reserved;
        int acc; bit ok; rsp_t r;
        slave_delay = 5; rsp_ready = 1'b1;
        push_cmd(2'd3, 32'h0000_0050, 32'h0, 4'hF, 4'd7, acc, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL rsvd_accept: got none want accepted"); end
        wait_rsp(1, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL rsvd_rsp_timeout: got %0d rsps want 1", rsp_obs.size()); end
        n_checks++; if (st_obs.size() != 0) begin n_fails++; $display("FAIL rsvd_no_start: got %0d starts want 0", st_obs.size()); end
        if (rsp_obs.size() > 0) begin
            r = rsp_obs.pop_front();
            n_checks++; if (r.tag !== 4'd7 || r.typ !== 2'd3) begin n_fails++; $display("FAIL rsvd_rsp_tag: tag %0d type %0d want 7 / 3", r.tag, r.typ); end
            n_checks++; if (r.err !== 1'b1 || r.rdata !== 32'h0) begin n_fails++; $display("FAIL rsvd_rsp_err: err %b rdata %h want 1 / 0", r.err, r.rdata); end
            n_checks++; if (r.cyc > acc + 3) begin n_fails++; $display("FAIL rsvd_rsp_latency: got cycle %0d want <= %0d", r.cyc, acc + 3); end
        end
        rsp_obs.delete(); st_obs.delete();
    endtask

    task automatic test_put_get;
        int acc; bit ok; rsp_t r, e; st_t s, se;
        slave_delay = 5; rsp_ready = 1'b1;
        st_exp.push_back('{typ: 2'd1, addr: 32'h20, cyc: 0});
        rsp_exp.push_back('{tag: 4'd1, typ: 2'd1, rdata: 32'h0, err: 1'b0, cyc: 0});
        push_cmd(2'd1, 32'h0000_0020, 32'h1234_5678, 4'hF, 4'd1, acc, ok);
        st_exp.push_back('{typ: 2'd0, addr: 32'h20, cyc: 0});
        rsp_exp.push_back('{tag: 4'd2, typ: 2'd0, rdata: 32'h1234_5678, err: 1'b0, cyc: 0});
        push_cmd(2'd0, 32'h0000_0020, 32'h0, 4'hF, 4'd2, acc, ok);
        wait_rsp(2, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL pg_rsp_timeout: got %0d rsps want 2", rsp_obs.size()); end
        while (st_exp.size() > 0) begin
            se = st_exp.pop_front();
            n_checks++;
            if (st_obs.size() == 0) begin n_fails++; $display("FAIL pg_start_missing: got none want addr %h", se.addr); end
            else begin
                s = st_obs.pop_front();
                if (s.typ !== se.typ || s.addr !== se.addr) begin n_fails++; $display("FAIL pg_start: type %0d addr %h want %0d / %h", s.typ, s.addr, se.typ, se.addr); end
            end
        end
        while (rsp_exp.size() > 0) begin
            e = rsp_exp.pop_front();
            n_checks++;
            if (rsp_obs.size() == 0) begin n_fails++; $display("FAIL pg_rsp_missing: got none want tag %0d", e.tag); end
            else begin
                r = rsp_obs.pop_front();
                if (r.tag !== e.tag || r.typ !== e.typ || r.rdata !== e.rdata || r.err !== e.err)
                    begin n_fails++; $display("FAIL pg_rsp: tag %0d type %0d rdata %h err %b want %0d %0d %h %b", r.tag, r.typ, r.rdata, r.err, e.tag, e.typ, e.rdata, e.err); end
            end
        end
        rsp_obs.delete(); st_obs.delete();
    endtask

    task automatic test_fifo_full;
        int acc, acc5; bit ok, ok5; rsp_t r, e; st_t s, se;
        slave_delay = 5; rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            st_exp.push_back('{typ: 2'd0, addr: 32'h40 + 4 * k, cyc: 0});
            rsp_exp.push_back('{tag: TW'(k), typ: 2'd0, rdata: 32'hA000_0000 + k, err: 1'b0, cyc: 0});
        end
        for (int k = 0; k < 5; k++) begin
            push_cmd(2'd0, 32'h40 + 4 * k, 32'h0, 4'hF, TW'(k), acc, ok);
            n_checks++; if (!ok) begin n_fails++; $display("FAIL full_accept: cmd %0d got none want accepted", k); end
        end
        for (int i = 0; i < 100 && rsp_valid !== 1'b1; i++) @(negedge clk_24);
        @(negedge clk_24);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fails++; $display("FAIL full_rsp_held: got %b want 1", rsp_valid); end
        n_checks++; if (cmd_count !== 3'd4) begin n_fails++; $display("FAIL full_count: got %0d want 4", cmd_count); end
        n_checks++; if (busy !== 1'b1 || rsp_tag !== 4'd0) begin n_fails++; $display("FAIL full_busy_tag: busy %b tag %0d want 1 / 0", busy, rsp_tag); end
        fork
            push_cmd(2'd0, 32'h54, 32'h0, 4'hF, 4'd5, acc5, ok5);
            begin
                repeat (4) begin
                    @(negedge clk_24);
                    n_checks++; if (cmd_ready !== 1'b0 || cmd_count !== 3'd4) begin n_fails++; $display("FAIL full_ready: ready %b count %0d want 0 / 4", cmd_ready, cmd_count); end
                end
                n_checks++; if (rsp_obs.size() != 0) begin n_fails++; $display("FAIL full_stall: got %0d rsps want 0", rsp_obs.size()); end
                @(posedge clk_24);
                #1;
                rsp_ready = 1'b1;
            end
        join
        n_checks++; if (!ok5) begin n_fails++; $display("FAIL full_sixth_accept: got none want accepted"); end
        wait_rsp(6, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL full_rsp_timeout: got %0d rsps want 6", rsp_obs.size()); end
        while (st_exp.size() > 0) begin
            se = st_exp.pop_front();
            n_checks++;
            if (st_obs.size() == 0) begin n_fails++; $display("FAIL full_start_missing: got none want addr %h", se.addr); end
            else begin
                s = st_obs.pop_front();
                if (s.typ !== se.typ || s.addr !== se.addr) begin n_fails++; $display("FAIL full_start: type %0d addr %h want %0d / %h", s.typ, s.addr, se.typ, se.addr); end
            end
        end
        while (rsp_exp.size() > 0) begin
            e = rsp_exp.pop_front();
            n_checks++;
            if (rsp_obs.size() == 0) begin n_fails++; $display("FAIL full_rsp_missing: got none want tag %0d", e.tag); end
            else begin
                r = rsp_obs.pop_front();
                if (r.tag !== e.tag || r.rdata !== e.rdata || r.err !== e.err)
                    begin n_fails++; $display("FAIL full_rsp_order: tag %0d rdata %h err %b want %0d %h %b", r.tag, r.rdata, r.err, e.tag, e.rdata, e.err); end
            end
        end
        rsp_obs.delete(); st_obs.delete();
    endtask

    task automatic test_timeout;
        int acc; bit ok; rsp_t r; st_t s;
        slave_delay = 0; rsp_ready = 1'b1;
        push_cmd(2'd0, 32'h0000_0030, 32'h0, 4'hF, 4'd9, acc, ok);
        for (int i = 0; i < 50 && st_obs.size() == 0; i++) @(negedge clk_24);
        n_checks++; if (st_obs.size() != 1) begin n_fails++; $display("FAIL to_start: got %0d starts want 1", st_obs.size()); end
        repeat (8) @(negedge clk_24);
        n_checks++; if (address !== 32'h30 || trans_type !== 2'd0 || rsp_valid !== 1'b0)
            begin n_fails++; $display("FAIL to_hold: addr %h type %0d rsp_valid %b want 30 / 0 / 0", address, trans_type, rsp_valid); end
        wait_rsp(1, ok);
        n_checks++; if (!ok) begin n_fails++; $display("FAIL to_rsp_timeout: got %0d rsps want 1", rsp_obs.size()); end
        if (rsp_obs.size() > 0 && st_obs.size() > 0) begin
            r = rsp_obs.pop_front();
            s = st_obs.pop_front();
            n_checks++; if (r.tag !== 4'd9 || r.err !== 1'b1 || r.rdata !== 32'h0)
                begin n_fails++; $display("FAIL to_rsp: tag %0d err %b rdata %h want 9 / 1 / 0", r.tag, r.err, r.rdata); end
            n_checks++; if (r.cyc != s.cyc + 1 + TO) begin n_fails++; $display("FAIL to_latency: got cycle %0d want %0d", r.cyc, s.cyc + 1 + TO); end
        end
        @(posedge clk_24); #1; manual_done = 1'b1;
        @(posedge clk_24); #1; manual_done = 1'b0;
        repeat (5) @(negedge clk_24);
        n_checks++; if (rsp_obs.size() != 0 || rsp_valid !== 1'b0 || busy !== 1'b0)
            begin n_fails++; $display("FAIL to_stray_done: rsps %0d rsp_valid %b busy %b want 0 / 0 / 0", rsp_obs.size(), rsp_valid, busy); end
        rsp_obs.delete(); st_obs.delete();
    endtask

    task automatic test_reset_mid_wait;
        int acc; bit ok;
        slave_delay = 0; rsp_ready = 1'b1;
        push_cmd(2'd0, 32'h0000_0010, 32'h0, 4'hF, 4'd11, acc, ok);
        for (int i = 0; i < 50 && st_obs.size() == 0; i++) @(negedge clk_24);
        n_checks++; if (st_obs.size() != 1) begin n_fails++; $display("FAIL rst_start: got %0d starts want 1", st_obs.size()); end
        st_obs.delete();
        repeat (2) @(posedge clk_24);
        #1; rst = 1'b1;
        @(posedge clk_24);
        #1; rst = 1'b0;
        @(negedge clk_24);
        n_checks++; if (rsp_valid !== 1'b0 || start_trans !== 1'b0) begin n_fails++; $display("FAIL rst_mid_outputs: rsp_valid %b start %b want 0 / 0", rsp_valid, start_trans); end
        n_checks++; if (cmd_count !== 3'd0 || busy !== 1'b0) begin n_fails++; $display("FAIL rst_mid_state: count %0d busy %b want 0 / 0", cmd_count, busy); end
        n_checks++; if (address !== 32'h0) begin n_fails++; $display("FAIL rst_mid_addr: got %h want 0", address); end
        @(posedge clk_24); #1; manual_done = 1'b1;
        @(posedge clk_24); #1; manual_done = 1'b0;
        repeat (6) @(negedge clk_24);
        n_checks++; if (rsp_obs.size() != 0 || rsp_valid !== 1'b0 || st_obs.size() != 0)
            begin n_fails++; $display("FAIL rst_late_done: rsps %0d rsp_valid %b starts %0d want 0 / 0 / 0", rsp_obs.size(), rsp_valid, st_obs.size()); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_addr = '0; cmd_size = '0;
        cmd_wdata = '0; cmd_wmask = '0; cmd_tag = '0; rsp_ready = 1'b0; manual_done = 1'b0;
        test_reset();
        test_single_get();
        test_reserved();
        test_put_get();
        test_fifo_full();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
